// File: rtl/ll_src_pack64.sv
// Packs 32-bit local-link FIFO words into 64-bit beats for the core's source port.
// Define LL_PACK_STAT_EN to compile in the per-frame byte accounting.
module ll_src_pack64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] in_data,
  input  logic        in_empty,
  output logic        in_rd,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic [3:0]  out_bytes,
  output logic        out_empty,
  input  logic        out_getn,
  output logic        frame_done,
  output logic [31:0] frame_bytes,
  output logic        sop_err
);

  typedef enum logic {EVEN, ODD} state_e;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [3:0]  bytes;
  } beat_t;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [1:0]  cnt_q;
  beat_t       head_q, tail_q, wbeat;
  logic        sop_err_q;
  logic        wr, err_set, pop, ob_full;

  logic        sop_n, eop_n;
  logic [1:0]  rem;
  logic [31:0] wd;

  assign sop_n   = in_data[35];
  assign eop_n   = in_data[34];
  assign rem     = in_data[33:32];
  assign wd      = in_data[31:0];
  assign ob_full = (cnt_q == 2'd2);
  assign pop     = !out_getn && (cnt_q != 2'd0);

  always_comb begin
    in_rd   = 1'b0;
    wr      = 1'b0;
    err_set = 1'b0;
    wbeat   = '0;
    state_d = state_q;
    hi_d    = hi_q;
    if (rst_n && !in_empty && !ob_full) begin
      if (state_q == EVEN) begin
        in_rd = 1'b1;
        if (!eop_n) begin
          wr          = 1'b1;
          wbeat.data  = {wd, 32'h0};
          wbeat.last  = 1'b1;
          wbeat.bytes = 4'd4 - {2'b00, rem};
        end else begin
          hi_d    = wd;
          state_d = ODD;
        end
      end else if (sop_n) begin
        in_rd       = 1'b1;
        wr          = 1'b1;
        wbeat.data  = {hi_q, wd};
        wbeat.last  = !eop_n;
        wbeat.bytes = eop_n ? 4'd8 : 4'd8 - {2'b00, rem};
        state_d     = EVEN;
      end else begin
        // New frame started mid-pair: flush the held half, keep the head for EVEN.
        wr          = 1'b1;
        err_set     = 1'b1;
        wbeat.data  = {hi_q, 32'h0};
        wbeat.last  = 1'b1;
        wbeat.bytes = 4'd4;
        state_d     = EVEN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EVEN;
      hi_q      <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      sop_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      if (err_set) sop_err_q <= 1'b1;
      case (cnt_q)
        2'd0: if (wr) begin head_q <= wbeat; cnt_q <= 2'd1; end
        2'd1: begin
          if (pop && wr)  head_q <= wbeat;
          else if (pop)   cnt_q  <= 2'd0;
          else if (wr)    begin tail_q <= wbeat; cnt_q <= 2'd2; end
        end
        default: if (pop) begin head_q <= tail_q; cnt_q <= 2'd1; end
      endcase
    end
  end

  assign out_data  = head_q.data;
  assign out_last  = head_q.last;
  assign out_bytes = head_q.bytes;
  assign out_empty = (cnt_q == 2'd0);
  assign sop_err   = sop_err_q;

`ifdef LL_PACK_STAT_EN
  logic [31:0] acc_q, fb_q, sat;
  logic [32:0] sum;
  logic        fd_q;

  assign sum = {1'b0, acc_q} + {29'b0, wbeat.bytes};
  assign sat = sum[32] ? 32'hFFFF_FFFF : sum[31:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      fb_q  <= '0;
      fd_q  <= 1'b0;
    end else begin
      fd_q <= wr && wbeat.last;
      if (wr) begin
        if (wbeat.last) begin
          fb_q  <= sat;
          acc_q <= '0;
        end else begin
          acc_q <= sat;
        end
      end
    end
  end

  assign frame_bytes = fb_q;
  assign frame_done  = fd_q;
`else
  assign frame_bytes = 32'h0;
  assign frame_done  = 1'b0;
`endif

endmodule

// File: tb/tb_ll_src_pack64.sv
// Directed bench for ll_src_pack64: FIFO model on the input, hand-computed beats on the output.
module tb_ll_src_pack64;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [35:0] in_data;
  logic        in_empty;
  logic        in_rd;
  logic [63:0] out_data;
  logic        out_last;
  logic [3:0]  out_bytes;
  logic        out_empty;
  logic        out_getn;
  logic        frame_done;
  logic [31:0] frame_bytes;
  logic        sop_err;

`ifdef LL_PACK_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  ll_src_pack64 dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_empty(in_empty), .in_rd(in_rd),
    .out_data(out_data), .out_last(out_last), .out_bytes(out_bytes), .out_empty(out_empty),
    .out_getn(out_getn), .frame_done(frame_done), .frame_bytes(frame_bytes), .sop_err(sop_err)
  );

  always #5 clk = ~clk;

  // First-word-fall-through FIFO model
  logic [35:0] fifo_mem [0:63];
  logic [5:0]  wr_idx = '0;
  logic [5:0]  rd_idx = '0;
  assign in_empty = (rd_idx == wr_idx);
  assign in_data  = fifo_mem[rd_idx];
  always @(posedge clk) if (in_rd && !in_empty) rd_idx <= rd_idx + 6'd1;

  int fd_cnt = 0;
  always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic sop_n, input logic eop_n, input logic [1:0] rem, input logic [31:0] d);
    fifo_mem[wr_idx] = {sop_n, eop_n, rem, d};
    wr_idx = wr_idx + 6'd1;
  endtask

  task automatic pop_beat(input string tag, input logic [63:0] d, input logic l, input logic [3:0] b);
    int n = 0;
    while (out_empty && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_vld"}, {63'h0, out_empty}, 64'h0);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_last"}, {63'h0, out_last}, {63'h0, l});
    chk({tag, "_bytes"}, {60'h0, out_bytes}, {60'h0, b});
    out_getn = 1'b0;
    @(negedge clk);
    out_getn = 1'b1;
  endtask

  initial begin
    logic [5:0] base;
    for (int i = 0; i < 64; i++) fifo_mem[i] = '0;
    rst_n    = 1'b0;
    out_getn = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state, with a word already waiting in the FIFO
    push(1'b0, 1'b0, 2'b01, 32'h11223344);
    #1;
    chk("rst_in_rd", {63'h0, in_rd}, 64'h0);
    @(negedge clk);
    chk("rst_empty", {63'h0, out_empty}, 64'h1);
    chk("rst_data", out_data, 64'h0);
    chk("rst_last", {63'h0, out_last}, 64'h0);
    chk("rst_bytes", {60'h0, out_bytes}, 64'h0);
    chk("rst_sop_err", {63'h0, sop_err}, 64'h0);
    chk("rst_fdone", {63'h0, frame_done}, 64'h0);
    chk("rst_fbytes", {32'h0, frame_bytes}, 64'h0);

    // Single-word frame, rem 01 -> 3 bytes
    rst_n = 1'b1;
    #1;
    chk("s1_in_rd", {63'h0, in_rd}, 64'h1);
    @(negedge clk);
    chk("s1_fdone", {63'h0, frame_done}, {63'h0, STAT});
    chk("s1_fbytes", {32'h0, frame_bytes}, STAT ? 64'd3 : 64'd0);
    pop_beat("s1", 64'h11223344_00000000, 1'b1, 4'd3);
    chk("s1_drained", {63'h0, out_empty}, 64'h1);

    // Three-word frame
    push(1'b0, 1'b1, 2'b00, 32'hA0A0A0A0);
    push(1'b1, 1'b1, 2'b00, 32'hB1B1B1B1);
    push(1'b1, 1'b0, 2'b00, 32'hC2C2C2C2);
    pop_beat("w3_b1", 64'hA0A0A0A0_B1B1B1B1, 1'b0, 4'd8);
    pop_beat("w3_b2", 64'hC2C2C2C2_00000000, 1'b1, 4'd4);
    chk("w3_fbytes", {32'h0, frame_bytes}, STAT ? 64'd12 : 64'd0);

    // Backpressure: six words, buffer fills after four pops
    base = rd_idx;
    push(1'b0, 1'b1, 2'b00, 32'h00000010);
    push(1'b1, 1'b1, 2'b00, 32'h00000011);
    push(1'b1, 1'b1, 2'b00, 32'h00000012);
    push(1'b1, 1'b1, 2'b00, 32'h00000013);
    push(1'b1, 1'b1, 2'b00, 32'h00000014);
    push(1'b1, 1'b0, 2'b11, 32'h00000015);
    repeat (8) @(negedge clk);
    chk("bp_pops", {58'h0, rd_idx - base}, 64'd4);
    chk("bp_in_rd", {63'h0, in_rd}, 64'h0);
    pop_beat("bp_b1", 64'h00000010_00000011, 1'b0, 4'd8);
    pop_beat("bp_b2", 64'h00000012_00000013, 1'b0, 4'd8);
    pop_beat("bp_b3", 64'h00000014_00000015, 1'b1, 4'd5);
    repeat (4) @(negedge clk);
    chk("bp_empty", {63'h0, out_empty}, 64'h1);
    chk("bp_fifo", {58'h0, wr_idx - rd_idx}, 64'd0);
    chk("bp_fbytes", {32'h0, frame_bytes}, STAT ? 64'd21 : 64'd0);

    // Framing error: sop arrives while a half is held
    push(1'b0, 1'b1, 2'b00, 32'hAAAA0001);
    push(1'b0, 1'b0, 2'b10, 32'hBBBB0002);
    @(negedge clk);
    chk("fe_hold", {63'h0, in_rd}, 64'h0);
    @(negedge clk);
    chk("fe_sop_err", {63'h0, sop_err}, 64'h1);
    chk("fe_in_rd", {63'h0, in_rd}, 64'h1);
    pop_beat("fe_b1", 64'hAAAA0001_00000000, 1'b1, 4'd4);
    pop_beat("fe_b2", 64'hBBBB0002_00000000, 1'b1, 4'd2);
    chk("fe_fbytes", {32'h0, frame_bytes}, STAT ? 64'd2 : 64'd0);

    // Reset mid-pair, with a beat sitting in the buffer
    push(1'b0, 1'b0, 2'b00, 32'h0000_00EE);
    push(1'b0, 1'b1, 2'b00, 32'hAAAA0003);
    repeat (2) @(negedge clk);
    chk("rm_buffered", {63'h0, out_empty}, 64'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rm_empty", {63'h0, out_empty}, 64'h1);
    chk("rm_sop_err", {63'h0, sop_err}, 64'h0);
    chk("rm_fbytes", {32'h0, frame_bytes}, 64'h0);
    push(1'b1, 1'b0, 2'b00, 32'hDDDD0004);
    pop_beat("rm_b1", 64'hDDDD0004_00000000, 1'b1, 4'd4);
    repeat (3) @(negedge clk);
    chk("fdone_pulses", 64'(fd_cnt), STAT ? 64'd7 : 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
